// File: rtl/eth_mmio_bridge_pkg.sv
// Shared types and constants for the ethernet MMIO bridge.
package eth_mmio_bridge_pkg;

    localparam int unsigned eth_reg_addr_width_gp = 14;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWaitRd,
        StResp
    } bridge_state_e;

endpackage

// File: rtl/ethernet_mmio_bridge.sv
// Valid/ready MMIO request/response bus to ethernet_controller strobe interface, one op in flight.
// Optional read-return timeout enabled by defining ETH_MMIO_BRIDGE_TIMEOUT_EN.
module ethernet_mmio_bridge
    import eth_mmio_bridge_pkg::*;
#(
    parameter int unsigned data_width_p = 32,
    parameter int unsigned bus_addr_width_p = 32,
    parameter logic [bus_addr_width_p-1:0] base_addr_p = '0,
    parameter int unsigned timeout_cycles_p = 64,
    localparam int unsigned max_size_lp = (data_width_p / 8 == 1) ? 1 : $clog2(data_width_p / 8),
    localparam int unsigned size_width_lp = $clog2(max_size_lp + 1)
) (
    input  logic                                  clk_i,
    input  logic                                  reset_i,
    input  logic                                  req_v_i,
    output logic                                  req_ready_o,
    input  logic                                  req_we_i,
    input  logic [bus_addr_width_p-1:0]           req_addr_i,
    input  logic [size_width_lp-1:0]              req_size_i,
    input  logic [data_width_p-1:0]               req_data_i,
    output logic                                  resp_v_o,
    input  logic                                  resp_ready_i,
    output logic                                  resp_we_o,
    output logic                                  resp_err_o,
    output logic [data_width_p-1:0]               resp_data_o,
    output logic [eth_reg_addr_width_gp-1:0]      addr_o,
    output logic                                  write_en_o,
    output logic                                  read_en_o,
    output logic [size_width_lp-1:0]              op_size_o,
    output logic [data_width_p-1:0]               write_data_o,
    input  logic [data_width_p-1:0]               read_data_i,
    input  logic                                  read_data_v_i
);

    bridge_state_e                     state_q;
    logic                              ready_q;
    logic                              we_q;
    logic                              err_q;
    logic                              resp_v_q;
    logic                              wen_q;
    logic                              ren_q;
    logic [eth_reg_addr_width_gp-1:0]  addr_q;
    logic [size_width_lp-1:0]          size_q;
    logic [data_width_p-1:0]           wdata_q;
    logic [data_width_p-1:0]           rdata_q;

    logic       window_ok;
    logic       size_ok;
    logic       align_ok;
    logic       req_err;
    logic [7:0] align_mask;

    always_comb begin
        window_ok  = req_addr_i[bus_addr_width_p-1:eth_reg_addr_width_gp]
                     == base_addr_p[bus_addr_width_p-1:eth_reg_addr_width_gp];
        size_ok    = 32'(req_size_i) <= max_size_lp;
        align_mask = (8'd1 << req_size_i) - 8'd1;
        align_ok   = (req_addr_i[7:0] & align_mask) == 8'd0;
        req_err    = !(window_ok && size_ok && align_ok);
    end

`ifdef ETH_MMIO_BRIDGE_TIMEOUT_EN
    localparam int unsigned cnt_width_lp = $clog2(timeout_cycles_p + 1);
    logic [cnt_width_lp-1:0] cnt_q;
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= StIdle;
            ready_q  <= 1'b0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            resp_v_q <= 1'b0;
            wen_q    <= 1'b0;
            ren_q    <= 1'b0;
            addr_q   <= '0;
            size_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
`ifdef ETH_MMIO_BRIDGE_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else begin
            wen_q <= 1'b0;
            ren_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // ready rises one cycle after reset release, so no accept while it is low
                    ready_q <= 1'b1;
                    if (req_v_i && ready_q) begin
                        ready_q <= 1'b0;
                        we_q    <= req_we_i;
                        addr_q  <= req_addr_i[eth_reg_addr_width_gp-1:0];
                        size_q  <= req_size_i;
                        wdata_q <= req_data_i;
                        rdata_q <= '0;
                        if (req_err) begin
                            err_q    <= 1'b1;
                            resp_v_q <= 1'b1;
                            state_q  <= StResp;
                        end else begin
                            err_q   <= 1'b0;
                            wen_q   <= req_we_i;
                            ren_q   <= !req_we_i;
                            state_q <= StIssue;
                        end
                    end
                end
                StIssue: begin
`ifdef ETH_MMIO_BRIDGE_TIMEOUT_EN
                    cnt_q <= '0;
`endif
                    if (we_q) begin
                        resp_v_q <= 1'b1;
                        state_q  <= StResp;
                    end else begin
                        state_q <= StWaitRd;
                    end
                end
                StWaitRd: begin
                    if (read_data_v_i) begin
                        rdata_q  <= read_data_i;
                        resp_v_q <= 1'b1;
                        state_q  <= StResp;
                    end
`ifdef ETH_MMIO_BRIDGE_TIMEOUT_EN
                    else if (cnt_q == cnt_width_lp'(timeout_cycles_p - 1)) begin
                        err_q    <= 1'b1;
                        rdata_q  <= '0;
                        resp_v_q <= 1'b1;
                        state_q  <= StResp;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                StResp: begin
                    if (resp_ready_i) begin
                        resp_v_q <= 1'b0;
                        ready_q  <= 1'b1;
                        state_q  <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    rd_v_only_in_wait: assert property (@(posedge clk_i) disable iff (reset_i)
        read_data_v_i |-> state_q == StWaitRd)
        else $error("read_data_v_i asserted outside WAIT_RD");

    assign req_ready_o  = ready_q;
    assign resp_v_o     = resp_v_q;
    assign resp_we_o    = we_q & resp_v_q;
    assign resp_err_o   = err_q & resp_v_q;
    assign resp_data_o  = rdata_q;
    assign addr_o       = addr_q;
    assign write_en_o   = wen_q;
    assign read_en_o    = ren_q;
    assign op_size_o    = size_q;
    assign write_data_o = wdata_q;

endmodule

// File: tb/tb_ethernet_mmio_bridge.sv
// Self-checking bench for ethernet_mmio_bridge; the bench also plays the synchronous controller.
module tb_ethernet_mmio_bridge;

    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_v = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [1:0]  req_size = '0;
    logic [31:0] req_data = '0;
    logic        resp_v;
    logic        resp_ready = 1'b0;
    logic        resp_we;
    logic        resp_err;
    logic [31:0] resp_data;
    logic [13:0] addr;
    logic        write_en;
    logic        read_en;
    logic [1:0]  op_size;
    logic [31:0] write_data;
    logic [31:0] read_data = '0;
    logic        read_data_v = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ethernet_mmio_bridge #(
        .data_width_p     (32),
        .bus_addr_width_p (32),
        .base_addr_p      (BASE),
        .timeout_cycles_p (TMO)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .req_v_i       (req_v),
        .req_ready_o   (req_ready),
        .req_we_i      (req_we),
        .req_addr_i    (req_addr),
        .req_size_i    (req_size),
        .req_data_i    (req_data),
        .resp_v_o      (resp_v),
        .resp_ready_i  (resp_ready),
        .resp_we_o     (resp_we),
        .resp_err_o    (resp_err),
        .resp_data_o   (resp_data),
        .addr_o        (addr),
        .write_en_o    (write_en),
        .read_en_o     (read_en),
        .op_size_o     (op_size),
        .write_data_o  (write_data),
        .read_data_i   (read_data),
        .read_data_v_i (read_data_v)
    );

    // Reference rule: outside window, oversize or misaligned requests are rejected.
    function automatic bit model_err(input logic [31:0] a, input int sz);
        if ((a >> 14) != (BASE >> 14)) return 1'b1;
        if (sz > 2) return 1'b1;
        if ((a % (32'd1 << sz)) != 0) return 1'b1;
        return 1'b0;
    endfunction

    // One full transaction: issue at a negedge, act as controller, check response, then handshake.
    task automatic do_op(input string name, input logic we, input logic [31:0] a, input int sz,
                         input logic [31:0] wd, input logic [31:0] rd, input int hold,
                         input bit drop_v);
        bit          exp_err;
        int          exp_lat;
        logic [31:0] exp_rdata;
        int          lat;
        int          strobes;
        bit          rd_pend;
        exp_err   = model_err(a, sz) || (!we && drop_v);
        exp_lat   = model_err(a, sz) ? 1 : (we ? 2 : (drop_v ? 2 + TMO : 3));
        exp_rdata = (exp_err || we) ? 32'h0 : rd;
        lat = 0;
        strobes = 0;
        rd_pend = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_before_req got=%b want=1", name, req_ready);
        end
        req_v = 1'b1;
        req_we = we;
        req_addr = a;
        req_size = 2'(sz);
        req_data = wd;
        @(negedge clk);
        req_v = 1'b0;
        req_data = $urandom;
        for (int k = 1; k <= 60; k++) begin
            read_data_v = rd_pend && !drop_v;
            read_data = rd_pend ? rd : $urandom;
            rd_pend = 1'b0;
            if (write_en || read_en) begin
                strobes++;
                checks++;
                if (k != 1 || write_en !== we || read_en !== !we || addr !== a[13:0]
                    || op_size !== 2'(sz) || write_data !== wd) begin
                    errors++;
                    $display("FAIL %s strobe cyc=%0d we=%b re=%b addr=%h size=%0d wd=%h want cyc=1 we=%b addr=%h size=%0d wd=%h",
                             name, k, write_en, read_en, addr, op_size, write_data, we,
                             a[13:0], sz, wd);
                end
                if (read_en) rd_pend = 1'b1;
            end
            if (resp_v === 1'b1) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        read_data_v = 1'b0;
        checks++;
        if (lat != exp_lat) begin
            errors++;
            $display("FAIL %s latency got=%0d want=%0d", name, lat, exp_lat);
        end
        if (lat == 0) return;
        checks++;
        if (strobes != (model_err(a, sz) ? 0 : 1)) begin
            errors++;
            $display("FAIL %s strobe_count got=%0d want=%0d", name, strobes,
                     model_err(a, sz) ? 0 : 1);
        end
        checks++;
        if (resp_err !== exp_err || resp_we !== we || resp_data !== exp_rdata) begin
            errors++;
            $display("FAIL %s resp err=%b we=%b data=%h want err=%b we=%b data=%h", name,
                     resp_err, resp_we, resp_data, exp_err, we, exp_rdata);
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            checks++;
            if (resp_v !== 1'b1 || req_ready !== 1'b0 || resp_err !== exp_err
                || resp_we !== we || resp_data !== exp_rdata) begin
                errors++;
                $display("FAIL %s hold%0d v=%b rdy=%b err=%b data=%h want v=1 rdy=0 err=%b data=%h",
                         name, h, resp_v, req_ready, resp_err, resp_data, exp_err, exp_rdata);
            end
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({req_ready, resp_v, write_en, read_en, resp_err, resp_we} !== 6'b0
            || addr !== '0 || op_size !== '0 || write_data !== '0 || resp_data !== '0) begin
            errors++;
            $display("FAIL %s outputs rdy=%b v=%b we=%b re=%b err=%b rwe=%b addr=%h sz=%0d wd=%h rd=%h want all 0",
                     name, req_ready, resp_v, write_en, read_en, resp_err, resp_we, addr,
                     op_size, write_data, resp_data);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release ready got=%b want=1", req_ready);
        end
    endtask

    task automatic test_write();
        do_op("write_dir", 1'b1, BASE + 32'h10, 2, 32'hA5A5_0001, 32'h0, 0, 1'b0);
        do_op("write_b", 1'b1, BASE + 32'h3FFF, 0, 32'h0000_00C3, 32'h0, 0, 1'b0);
    endtask

    task automatic test_read();
        do_op("read_dir", 1'b0, BASE + 32'h20, 2, 32'h0, 32'h1234_5678, 0, 1'b0);
        do_op("read_h", 1'b0, BASE + 32'h2A, 1, 32'h0, 32'hFFFF_BEEF, 0, 1'b0);
    endtask

    task automatic test_error();
        do_op("err_misalign", 1'b0, BASE + 32'h3, 1, 32'h0, 32'hDEAD_BEEF, 0, 1'b0);
        do_op("err_window", 1'b0, BASE + 32'h4000, 2, 32'h0, 32'hDEAD_BEEF, 0, 1'b0);
        do_op("err_size", 1'b1, BASE + 32'h8, 3, 32'h1111_2222, 32'h0, 0, 1'b0);
        do_op("err_wr_align", 1'b1, BASE + 32'h6, 2, 32'h3333_4444, 32'h0, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_op("bp_read", 1'b0, BASE + 32'h44, 2, 32'h0, 32'h0BAD_F00D, 5, 1'b0);
        do_op("b2b_write", 1'b1, BASE + 32'h48, 2, 32'h5555_AAAA, 32'h0, 5, 1'b0);
        do_op("b2b_err", 1'b1, 32'h0000_0010, 2, 32'h1, 32'h0, 2, 1'b0);
        do_op("b2b_read", 1'b0, BASE + 32'h48, 2, 32'h0, 32'h7777_0000, 0, 1'b0);
    endtask

    task automatic test_reset_mid_op();
        int seen;
        seen = 0;
        @(negedge clk);
        req_v = 1'b1;
        req_we = 1'b0;
        req_addr = BASE + 32'h1F0;
        req_size = 2'd2;
        @(negedge clk);
        req_v = 1'b0;
        for (int k = 0; k < 10 && seen == 0; k++) begin
            if (read_en) seen = 1;
            @(negedge clk);
        end
        checks++;
        if (seen != 1) begin
            errors++;
            $display("FAIL mid_reset read_strobe got=%0d want=1", seen);
        end
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("mid_reset");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (resp_v !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_drop v=%b rdy=%b want v=0 rdy=1", resp_v, req_ready);
        end
        do_op("after_reset", 1'b0, BASE + 32'h1F0, 2, 32'h0, 32'hCAFE_0123, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic        we;
            logic [31:0] a;
            int          sz;
            int          pick;
            we = 1'($urandom);
            sz = int'($urandom_range(0, 3));
            pick = int'($urandom_range(0, 9));
            if (pick == 0) a = $urandom;
            else a = BASE + ($urandom & 32'h3FFF);
            if (pick > 3 && sz <= 2) a = a & ~((32'd1 << sz) - 32'd1);
            do_op("random", we, a, sz, $urandom, $urandom, int'($urandom_range(0, 3)), 1'b0);
        end
    endtask

`ifdef ETH_MMIO_BRIDGE_TIMEOUT_EN
    task automatic test_timeout();
        do_op("timeout", 1'b0, BASE + 32'h30, 2, 32'h0, 32'h9999_9999, 1, 1'b1);
        do_op("post_timeout", 1'b0, BASE + 32'h34, 2, 32'h0, 32'h1357_2468, 0, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_read();
        test_error();
        test_back_to_back();
        test_reset_mid_op();
`ifdef ETH_MMIO_BRIDGE_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
